// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Multi-cycle controller for a small 8-bit accumulator-less machine. Every
// instruction walks FETCH -> DECODE -> EXEC -> WB, taking four cycles. The
// register file and the ALU are external; this block only sequences them.
//
// Optional feature macro: CU_BRANCH_EN
//   Defined   : opcode 7 (BEQ) and opcode D (JMP) are implemented.
//   Undefined : opcodes 7 and D are illegal and execute as NOP.
//
// Parameters
//   PC_WIDTH   width of the program counter
//   RESET_PC   program counter value loaded by reset
//
// Ports
//   clk         clock, all state changes on its rising edge
//   reset       asynchronous active-high reset
//   instr       instruction byte at address pc ([7:4] opcode, [3:2] rd/rs1,
//               [1:0] rs2)
//   reg1data    register-file read data for address reg1
//   reg2data    register-file read data for address reg2
//   alu_result  external ALU result for the current alu_op
//   pc          instruction-fetch address
//   rf_reset    register-file initialise request
//   rf_we       register-file write enable (one cycle, in WB)
//   reg1, reg2  register-file read addresses
//   wreg        register-file write address
//   wdata       register-file write data
//   alu_op      ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR
//   halted      high only while in the HALT state
//   illegal     sticky undefined-opcode flag
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int          PC_WIDTH = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          instr,
  input  logic [7:0]          reg1data,
  input  logic [7:0]          reg2data,
  input  logic [7:0]          alu_result,
  output logic [PC_WIDTH-1:0] pc,
  output logic                rf_reset,
  output logic                rf_we,
  output logic [1:0]          reg1,
  output logic [1:0]          reg2,
  output logic [1:0]          wreg,
  output logic [7:0]          wdata,
  output logic [1:0]          alu_op,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state;
  logic [7:0] ir;
  logic [3:0] opcode;

  assign opcode = ir[7:4];

  // Read addresses come straight from the instruction register, so they are
  // valid from DECODE onward and return to 0 whenever IR is cleared by reset.
  assign reg1 = ir[3:2];
  assign reg2 = ir[1:0];

  // The register file is held in initialisation for the whole reset pulse and
  // for the one INIT cycle that follows it.
  assign rf_reset = reset || (state == S_INIT);

  function automatic logic [1:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_op_of = 2'd1;
      OP_AND:  alu_op_of = 2'd2;
      OP_OR:   alu_op_of = 2'd3;
      default: alu_op_of = 2'd0;
    endcase
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    writes_reg = (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_HALT: is_illegal = 1'b0;
`ifdef CU_BRANCH_EN
      OP_BEQ, OP_JMP:                                         is_illegal = 1'b0;
`endif
      default:                                                is_illegal = 1'b1;
    endcase
  endfunction

  // Main sequencer. wdata doubles as the latched EXEC result: the ALU value,
  // the MOV/JMP operand, or the BEQ compare in bit 0. Latching it for opcodes
  // that do not write is harmless because wdata is ignored while rf_we is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_INIT;
      pc      <= PC_WIDTH'(RESET_PC);
      ir      <= '0;
      rf_we   <= 1'b0;
      wreg    <= '0;
      wdata   <= '0;
      alu_op  <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          state <= S_FETCH;
        end

        S_FETCH: begin
          ir     <= instr;
          alu_op <= alu_op_of(instr[7:4]);
          state  <= S_DECODE;
        end

        S_DECODE: begin
          if (is_illegal(opcode)) begin
            illegal <= 1'b1;
          end
          state <= S_EXEC;
        end

        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: wdata <= alu_result;
            OP_MOV, OP_JMP:                wdata <= reg2data;
            OP_BEQ:                        wdata <= {7'b0, reg1data == reg2data};
            default:                       wdata <= wdata;
          endcase
          rf_we <= writes_reg(opcode);
          wreg  <= ir[3:2];
          state <= S_EXEC == S_EXEC ? S_WB : S_WB;
        end

        S_WB: begin
          rf_we <= 1'b0;
          if (opcode == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            state <= S_FETCH;
`ifdef CU_BRANCH_EN
            if (opcode == OP_BEQ) begin
              pc <= pc + (wdata[0] ? PC_WIDTH'(2) : PC_WIDTH'(1));
            end else if (opcode == OP_JMP) begin
              pc <= PC_WIDTH'(wdata);
            end else begin
              pc <= pc + PC_WIDTH'(1);
            end
`else
            pc <= pc + PC_WIDTH'(1);
`endif
          end
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Directed bench for control_unit. The bench owns a 256-byte instruction
// memory, a four-entry register file that loads initVals on rf_reset and
// writes on the negedge after rf_we, and a behavioural ALU. Outputs are
// sampled on the falling edge; inputs change on the falling edge as well.
// -----------------------------------------------------------------------------
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic [7:0] reg1data;
  logic [7:0] reg2data;
  logic [7:0] alu_result;
  logic [7:0] pc;
  logic       rf_reset;
  logic       rf_we;
  logic [1:0] reg1;
  logic [1:0] reg2;
  logic [1:0] wreg;
  logic [7:0] wdata;
  logic [1:0] alu_op;
  logic       halted;
  logic       illegal;

  logic [7:0] imem [256];
  logic [7:0] regs [4];
  logic [7:0] initVals [4];

  int checks = 0;
  int failures = 0;

  // Results captured by runInstr over one four-cycle instruction window.
  int         weCount;
  int         weStep;
  logic [1:0] wregSeen;
  logic [7:0] wdataSeen;
  logic [1:0] aluOpSeen;
  logic [1:0] r1Seen;
  logic [1:0] r2Seen;
  logic       haltedAtWb;

  always #5 clk = ~clk;

  control_unit #(
    .PC_WIDTH (8),
    .RESET_PC (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .reg1data   (reg1data),
    .reg2data   (reg2data),
    .alu_result (alu_result),
    .pc         (pc),
    .rf_reset   (rf_reset),
    .rf_we      (rf_we),
    .reg1       (reg1),
    .reg2       (reg2),
    .wreg       (wreg),
    .wdata      (wdata),
    .alu_op     (alu_op),
    .halted     (halted),
    .illegal    (illegal)
  );

  assign instr    = imem[pc];
  assign reg1data = regs[reg1];
  assign reg2data = regs[reg2];

  // Reference ALU driven by the controller's alu_op.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      2'd0: alu_result = reg1data + reg2data;
      2'd1: alu_result = reg1data - reg2data;
      2'd2: alu_result = reg1data & reg2data;
      2'd3: alu_result = reg1data | reg2data;
      default: alu_result = 8'h00;
    endcase
  end

  // Register file model: samples on the negedge that follows the write cycle.
  always @(negedge clk) begin
    if (rf_reset) begin
      regs <= initVals;
    end else if (rf_we) begin
      regs[wreg] <= wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string pre);
    checkOutput({pre, "_pc"},       32'(pc),       32'h0);
    checkOutput({pre, "_rf_reset"}, 32'(rf_reset), 32'h1);
    checkOutput({pre, "_rf_we"},    32'(rf_we),    32'h0);
    checkOutput({pre, "_halted"},   32'(halted),   32'h0);
    checkOutput({pre, "_illegal"},  32'(illegal),  32'h0);
    checkOutput({pre, "_alu_op"},   32'(alu_op),   32'h0);
    checkOutput({pre, "_reg1"},     32'(reg1),     32'h0);
    checkOutput({pre, "_reg2"},     32'(reg2),     32'h0);
    checkOutput({pre, "_wreg"},     32'(wreg),     32'h0);
    checkOutput({pre, "_wdata"},    32'(wdata),    32'h0);
  endtask

  // Pulse reset for two cycles, release on a falling edge and step past the
  // single INIT cycle so the caller resumes in FETCH.
  task automatic applyStimulus();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Observe one instruction from FETCH to the next FETCH (four falling edges).
  task automatic runInstr();
    weCount    = 0;
    weStep     = 0;
    wregSeen   = '0;
    wdataSeen  = '0;
    aluOpSeen  = '0;
    r1Seen     = '0;
    r2Seen     = '0;
    haltedAtWb = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      @(negedge clk);
      if (s == 1) begin
        aluOpSeen = alu_op;
        r1Seen    = reg1;
        r2Seen    = reg2;
      end
      if (s == 3) begin
        haltedAtWb = halted;
      end
      if (rf_we) begin
        weCount++;
        weStep    = s;
        wregSeen  = wreg;
        wdataSeen = wdata;
      end
    end
  endtask

  task automatic checkWrite(input string pre, input logic [1:0] expWreg, input logic [7:0] expWdata);
    checkOutput({pre, "_we_count"}, 32'(weCount),   32'd1);
    checkOutput({pre, "_we_step"},  32'(weStep),    32'd3);
    checkOutput({pre, "_wreg"},     32'(wregSeen),  32'(expWreg));
    checkOutput({pre, "_wdata"},    32'(wdataSeen), 32'(expWdata));
  endtask

  initial begin
    int weTotal;

    reset = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    for (int i = 0; i < 4; i++) initVals[i] = 8'(i);

    // Program 1: ADD, SUB, illegal 9x, MOV, OR, HALT.
    imem[0] = 8'h16;
    imem[1] = 8'h23;
    imem[2] = 8'h90;
    imem[3] = 8'h52;
    imem[4] = 8'h4B;
    imem[5] = 8'hF0;

    repeat (2) @(negedge clk);
    checkResetOutputs("reset_hold");
    reset = 1'b0;
    #1;
    checkOutput("init_rf_reset", 32'(rf_reset), 32'h1);
    @(negedge clk);
    checkOutput("fetch_rf_reset", 32'(rf_reset), 32'h0);
    checkOutput("fetch_pc",       32'(pc),       32'h0);

    // ADD r1,r2 : 1 + 2 = 3 into r1
    runInstr();
    checkOutput("add_reg1",   32'(r1Seen),    32'd1);
    checkOutput("add_reg2",   32'(r2Seen),    32'd2);
    checkOutput("add_alu_op", 32'(aluOpSeen), 32'd0);
    checkWrite("add", 2'd1, 8'h03);
    checkOutput("add_pc",     32'(pc),        32'h01);
    checkOutput("add_rf_we",  32'(rf_we),     32'h0);

    // SUB r0,r3 : 0 - 3 = 0xFD into r0
    runInstr();
    checkOutput("sub_alu_op", 32'(aluOpSeen), 32'd1);
    checkWrite("sub", 2'd0, 8'hFD);
    checkOutput("sub_pc",      32'(pc),      32'h02);
    checkOutput("sub_illegal", 32'(illegal), 32'h0);

    // Opcode 9: no write, sets illegal
    runInstr();
    checkOutput("op9_we_count", 32'(weCount), 32'd0);
    checkOutput("op9_illegal",  32'(illegal), 32'h1);
    checkOutput("op9_pc",       32'(pc),      32'h03);

    // MOV r0,r2 : r2 = 2
    runInstr();
    checkWrite("mov", 2'd0, 8'h02);
    checkOutput("mov_pc", 32'(pc), 32'h04);

    // OR r2,r3 : 2 | 3 = 3 into r2
    runInstr();
    checkOutput("or_alu_op", 32'(aluOpSeen), 32'd3);
    checkWrite("or", 2'd2, 8'h03);

    // HALT at pc 5
    runInstr();
    checkOutput("halt_we_count",  32'(weCount),    32'd0);
    checkOutput("halt_not_in_wb", 32'(haltedAtWb), 32'h0);
    checkOutput("halt_halted",    32'(halted),     32'h1);
    checkOutput("halt_pc",        32'(pc),         32'h05);
    repeat (20) @(negedge clk);
    checkOutput("halt_hold_pc",      32'(pc),      32'h05);
    checkOutput("halt_hold_halted",  32'(halted),  32'h1);
    checkOutput("halt_hold_illegal", 32'(illegal), 32'h1);

    // Reset during WB of ADD after an illegal opcode: immediate clear.
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    imem[0] = 8'h90;
    imem[1] = 8'h16;
    applyStimulus();
    runInstr();
    checkOutput("abort_pre_illegal", 32'(illegal), 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("abort_in_wb_we",    32'(rf_we), 32'h1);
    checkOutput("abort_in_wb_wdata", 32'(wdata), 32'h03);
    reset = 1'b1;
    #1;
    checkResetOutputs("abort");

    // NOP run through pc 0xFF: pc wraps to 0 with no writes.
    imem[0] = 8'h00;
    imem[1] = 8'h00;
    applyStimulus();
    weTotal = 0;
    for (int i = 0; i < 255; i++) begin
      runInstr();
      weTotal += weCount;
    end
    checkOutput("nop_pc_ff", 32'(pc), 32'hFF);
    runInstr();
    weTotal += weCount;
    checkOutput("nop_wrap_pc",   32'(pc),      32'h00);
    checkOutput("nop_we_total",  32'(weTotal), 32'd0);
    checkOutput("nop_illegal",   32'(illegal), 32'h0);

    // HALT at pc 0xFF stays there.
    imem[8'hFF] = 8'hF0;
    applyStimulus();
    for (int i = 0; i < 255; i++) runInstr();
    runInstr();
    checkOutput("halt_ff_halted", 32'(halted), 32'h1);
    checkOutput("halt_ff_pc",     32'(pc),     32'hFF);
    repeat (20) @(negedge clk);
    checkOutput("halt_ff_hold_pc",     32'(pc),     32'hFF);
    checkOutput("halt_ff_hold_halted", 32'(halted), 32'h1);
    imem[8'hFF] = 8'h00;

`ifdef CU_BRANCH_EN
    // BEQ r2,r2 at pc 4 -> 6; BEQ r0,r1 at 6 -> 7; JMP r3 (0x80) -> 0x80.
    initVals[3] = 8'h80;
    imem[4] = 8'h7A;
    imem[6] = 8'h71;
    imem[7] = 8'hD3;
    applyStimulus();
    for (int i = 0; i < 4; i++) runInstr();
    checkOutput("pre_beq_pc", 32'(pc), 32'h04);
    runInstr();
    checkOutput("beq_eq_pc", 32'(pc),      32'h06);
    checkOutput("beq_eq_we", 32'(weCount), 32'd0);
    runInstr();
    checkOutput("beq_ne_pc", 32'(pc),      32'h07);
    runInstr();
    checkOutput("jmp_pc",      32'(pc),      32'h80);
    checkOutput("jmp_we",      32'(weCount), 32'd0);
    checkOutput("branch_legal", 32'(illegal), 32'h0);
`else
    // Without branches, opcodes 7 and D are illegal NOPs.
    imem[0] = 8'h70;
    applyStimulus();
    runInstr();
    checkOutput("op7_illegal", 32'(illegal), 32'h1);
    checkOutput("op7_pc",      32'(pc),      32'h01);
    checkOutput("op7_we",      32'(weCount), 32'd0);
    imem[0] = 8'h00;
    imem[1] = 8'hD3;
    applyStimulus();
    runInstr();
    checkOutput("opD_pre_illegal", 32'(illegal), 32'h0);
    runInstr();
    checkOutput("opD_illegal", 32'(illegal), 32'h1);
    checkOutput("opD_pc",      32'(pc),      32'h02);
    checkOutput("opD_we",      32'(weCount), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
